// File: rtl/pipe_idex_reg.sv
// pipe_idex_reg
//   ID/EXE pipeline register between the decode stage and the ALU stage.
//   Carries operands, immediate, PC+4, destination register number and a
//   generic control vector, with a valid bit, hold (stall), bubble insertion
//   (flush) and two saturating performance counters.
//
// Ports
//   clock              rising-edge clock
//   reset              synchronous, active-high reset
//   d_valid            decode stage holds a real instruction
//   d_ctrl             decoded control vector
//   d_a, d_b           operands A and B
//   d_imm              extended immediate
//   d_pc4              PC+4
//   d_rn               destination register number
//   stall              hold stage contents
//   flush              replace stage contents with a bubble
//   cnt_clr            clear both performance counters
//   e_valid            execute-stage instruction valid
//   e_ctrl             registered control vector (zero whenever e_valid=0)
//   e_a, e_b, e_imm,
//   e_pc4              registered data fields
//   e_rn               registered destination (zero whenever e_valid=0)
//   stall_cnt          cycles spent stalled (saturating)
//   bubble_cnt         bubbles inserted (saturating)

module pipe_idex_reg #(
  parameter int DATA_W = 32,
  parameter int RN_W   = 5,
  parameter int CTRL_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_a,
  input  logic [DATA_W-1:0] d_b,
  input  logic [DATA_W-1:0] d_imm,
  input  logic [DATA_W-1:0] d_pc4,
  input  logic [RN_W-1:0]   d_rn,
  input  logic              stall,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic              e_valid,
  output logic [CTRL_W-1:0] e_ctrl,
  output logic [DATA_W-1:0] e_a,
  output logic [DATA_W-1:0] e_b,
  output logic [DATA_W-1:0] e_imm,
  output logic [DATA_W-1:0] e_pc4,
  output logic [RN_W-1:0]   e_rn,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic hold;
  logic bubble_load;

  // A flush always beats a stall, so a held instruction can be squashed.
  assign hold        = stall & ~flush;
  // e_valid gets freshly written with 0: flush, or an unstalled empty slot.
  assign bubble_load = flush | (~stall & ~d_valid);

  always_ff @(posedge clock) begin
    if (reset) begin
      e_valid <= 1'b0;
      e_ctrl  <= '0;
      e_rn    <= '0;
      e_a     <= '0;
      e_b     <= '0;
      e_imm   <= '0;
      e_pc4   <= '0;
    end else if (flush) begin
      // Data fields keep their old contents; only the side-effect bits die.
      e_valid <= 1'b0;
      e_ctrl  <= '0;
      e_rn    <= '0;
    end else if (!stall) begin
      e_valid <= d_valid;
      // Gating ctrl/rn keeps the invariant that a bubble never writes state.
      e_ctrl  <= d_valid ? d_ctrl : '0;
      e_rn    <= d_valid ? d_rn   : '0;
      e_a     <= d_a;
      e_b     <= d_b;
      e_imm   <= d_imm;
      e_pc4   <= d_pc4;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || cnt_clr) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (hold && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (bubble_load && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule
